// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory port: access-width codes, responder
// state encoding and the access-shape legality check.
package mem_pkg;

   localparam logic [1:0] MEMW_BYTE = 2'b00;
   localparam logic [1:0] MEMW_HALF = 2'b01;
   localparam logic [1:0] MEMW_WORD = 2'b10;
   localparam logic [1:0] MEMW_RSVD = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } dmem_state_t;

   // True when the access cannot be performed as a single aligned lane access.
   // The reserved width code is lumped in so callers need only one fault term.
   function automatic logic misaligned(input logic [1:0] addr, input logic [1:0] width);
      logic bad;
      bad = 1'b0;
      case (width)
         MEMW_HALF: bad = addr[0];
         MEMW_WORD: bad = (addr != 2'b00);
         MEMW_RSVD: bad = 1'b1;
         default:   bad = 1'b0;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/mem_align.sv
// Little-endian lane steering for the load/store path. Store side produces
// byte enables and replicated write data; load side extracts the addressed
// lane(s) from a raw word and sign- or zero-extends the result.
module mem_align
   import mem_pkg::*;
(
   input  logic [1:0]  st_lane,
   input  logic [1:0]  st_width,
   input  logic [31:0] st_data,
   output logic [3:0]  st_be,
   output logic [31:0] st_wdata,
   input  logic [1:0]  ld_lane,
   input  logic [1:0]  ld_width,
   input  logic        ld_sext,
   input  logic [31:0] ld_word,
   output logic [31:0] ld_data
);

   logic [7:0]  ld_byte;
   logic [15:0] ld_half;

   // Store side: data is replicated across lanes so only the enables pick the target.
   always_comb begin
      st_be    = 4'b0000;
      st_wdata = st_data;
      case (st_width)
         MEMW_BYTE: begin
            st_be    = 4'b0001 << st_lane;
            st_wdata = {4{st_data[7:0]}};
         end
         MEMW_HALF: begin
            st_be    = st_lane[1] ? 4'b1100 : 4'b0011;
            st_wdata = {2{st_data[15:0]}};
         end
         MEMW_WORD: st_be = 4'b1111;
         default:   st_be = 4'b0000;
      endcase
   end

   // Load side: pick the lane(s), then extend to 32 bits.
   always_comb begin
      case (ld_lane)
         2'd0:    ld_byte = ld_word[7:0];
         2'd1:    ld_byte = ld_word[15:8];
         2'd2:    ld_byte = ld_word[23:16];
         default: ld_byte = ld_word[31:24];
      endcase
      ld_half = ld_lane[1] ? ld_word[31:16] : ld_word[15:0];
      case (ld_width)
         MEMW_BYTE: ld_data = {{24{ld_sext & ld_byte[7]}}, ld_byte};
         MEMW_HALF: ld_data = {{16{ld_sext & ld_half[15]}}, ld_half};
         MEMW_WORD: ld_data = ld_word;
         default:   ld_data = 32'h0;
      endcase
   end

endmodule

// File: rtl/data_mem.sv
// Data-memory responder for the hart load/store port: word-organised array,
// single outstanding request, fixed response latency of LATENCY cycles.
//
//   state | meaning
//   IDLE  | no request outstanding, ready to accept
//   WAIT  | request accepted, latency counter running, not ready
//   RESP  | response strobe cycle, ready to accept the next request
module data_mem
   import mem_pkg::*;
#(
   parameter int          DEPTH_WORDS = 1024,
   parameter int          LATENCY     = 1,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] addr,
   input  logic        we,
   input  logic        sext,
   input  logic [1:0]  width,
   input  logic [31:0] wdata,
   output logic        rvalid,
   output logic [31:0] rdata,
   output logic        fault
);

   localparam int         AW       = $clog2(DEPTH_WORDS);
   localparam logic [1:0] LAT_LAST = 2'(LATENCY - 1);

   logic [31:0] mem [DEPTH_WORDS];

   dmem_state_t state;
   logic [1:0]  cnt;

   logic [AW-1:0] r_idx;
   logic [1:0]    r_lane;
   logic [1:0]    r_width;
   logic          r_we;
   logic          r_sext;
   logic          r_fault;

   logic [31:0]   offset;
   logic [AW-1:0] idx;
   logic          in_range;
   logic          req_fault;
   logic          accept;

   logic [AW-1:0] src_idx;
   logic [1:0]    src_lane;
   logic [1:0]    src_width;
   logic          src_sext;

   logic [3:0]    st_be;
   logic [31:0]   st_wdata;
   logic [31:0]   ld_data;

   // BASE_ADDR is aligned to the array size, so the offset's low bits equal addr's.
   assign offset    = addr - BASE_ADDR;
   assign in_range  = (offset[31:AW+2] == '0);
   assign idx       = offset[AW+1:2];
   assign req_fault = misaligned(offset[1:0], width) | ~in_range;
   assign req_ready = reset & (state != WAIT);
   assign accept    = req_valid & req_ready;

   // With a single-cycle latency the response is formed at the accept edge, so
   // the live request feeds the read path; otherwise the registered copy does.
   assign src_idx   = (LATENCY == 1) ? idx          : r_idx;
   assign src_lane  = (LATENCY == 1) ? offset[1:0]  : r_lane;
   assign src_width = (LATENCY == 1) ? width        : r_width;
   assign src_sext  = (LATENCY == 1) ? sext         : r_sext;

   mem_align u_align (
      .st_lane  (offset[1:0]),
      .st_width (width),
      .st_data  (wdata),
      .st_be    (st_be),
      .st_wdata (st_wdata),
      .ld_lane  (src_lane),
      .ld_width (src_width),
      .ld_sext  (src_sext),
      .ld_word  (mem[src_idx]),
      .ld_data  (ld_data)
   );

   // Stores commit at the accept edge; faulted stores leave the array untouched.
   always_ff @(posedge clk) begin
      if (accept && we && !req_fault) begin
         for (int b = 0; b < 4; b++) begin
            if (st_be[b]) mem[idx][8*b +: 8] <= st_wdata[8*b +: 8];
         end
      end
   end

   // Request handshake, latency timing and registered response outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         cnt     <= 2'd0;
         rvalid  <= 1'b0;
         fault   <= 1'b0;
         rdata   <= 32'h0;
         r_idx   <= '0;
         r_lane  <= 2'd0;
         r_width <= 2'd0;
         r_we    <= 1'b0;
         r_sext  <= 1'b0;
         r_fault <= 1'b0;
      end else begin
         rvalid <= 1'b0;
         fault  <= 1'b0;
         rdata  <= 32'h0;
         case (state)
            IDLE, RESP: begin
               if (accept) begin
                  r_idx   <= idx;
                  r_lane  <= offset[1:0];
                  r_width <= width;
                  r_we    <= we;
                  r_sext  <= sext;
                  r_fault <= req_fault;
                  if (LATENCY > 1) begin
                     state <= WAIT;
                     cnt   <= 2'd1;
                  end else begin
                     state  <= RESP;
                     rvalid <= 1'b1;
                     fault  <= req_fault;
                     rdata  <= (!we && !req_fault) ? ld_data : 32'h0;
                  end
               end else begin
                  state <= IDLE;
               end
            end
            WAIT: begin
               if (cnt == LAT_LAST) begin
                  state  <= RESP;
                  rvalid <= 1'b1;
                  fault  <= r_fault;
                  rdata  <= (!r_we && !r_fault) ? ld_data : 32'h0;
               end else begin
                  cnt <= cnt + 2'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/data_mem.md
Name: data_mem

Overview:
- Data-memory responder for the hart's load/store port, i.e. the far end of the memaddr/memw/memsext/memwidth/memdata interface.
- Holds a word-organised SRAM array and performs little-endian byte/half/word steering on stores.
- On loads, performs lane extraction plus sign or zero extension.
- Adds a single-outstanding valid/ready request handshake with fixed, parameterised response latency, so the hart can later be pipelined against a non-zero-latency memory.

Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words in the array; power of two.
- LATENCY, 1: cycles from request acceptance to response; legal range 1..4.
- BASE_ADDR, 32'h0000_0000: byte address of word 0; aligned to DEPTH_WORDS*4.

Ports:
- clk  in  1: clock; all state updates on the rising edge.
- reset  in  1: asynchronous, active-low reset.
- req_valid  in  1: request present.
- req_ready  out  1: block can accept a request this cycle.
- addr  in  32: byte address (hart memaddr).
- we  in  1: 1 = store, 0 = load (hart memw).
- sext  in  1: sign-extend load result (hart memsext).
- width  in  2: 00 byte, 01 half, 10 word, 11 reserved (hart memwidth).
- wdata  in  32: store data, right-justified.
- rvalid  out  1: one-cycle response strobe, for loads and stores.
- rdata  out  32: load result; valid only while rvalid=1.
- fault  out  1: response carries an error; qualified by rvalid.

Behaviour:
- Reset (reset=0, async): state IDLE, latency counter 0, rvalid=0, fault=0, rdata=0, req_ready=0 while asserted. Array contents are not reset.
- States and transitions:
  - IDLE: req_ready=1. On accept: go to WAIT if LATENCY>1, else RESP.
  - WAIT: req_ready=0. Counter counts up to LATENCY-1, then go to RESP.
  - RESP: rvalid=1 for exactly this cycle; req_ready=1. On accept, re-enter WAIT or RESP; otherwise go to IDLE.
- Accept means req_valid=1 and req_ready=1 at a rising edge. The registered copy is taken at acceptance: addr, we, sext, width, wdata.
- Latency and throughput: a request accepted at edge N gives rvalid=1 in the cycle following edge N+LATENCY-1. Only one request is outstanding at a time. Maximum throughput is one request per LATENCY cycles.
- Fault conditions, evaluated at accept:
  - width=11;
  - half with addr[0]=1;
  - word with addr[1:0]!=0;
  - addr outside [BASE_ADDR, BASE_ADDR+DEPTH_WORDS*4).
- On fault: no array write, rdata=0, fault=1 in the response cycle. Latency is identical to the non-fault case.
- Stores:
  - Commit to the array at the acceptance edge.
  - Byte: wdata[7:0] to lane addr[1:0].
  - Half: wdata[15:0] to lanes {addr[1],0} and {addr[1],1}.
  - Word: all lanes.
  - Untouched lanes are preserved.
  - Store response has rdata=0.
- Loads:
  - Array is read from the registered word index; the result is registered into rdata for the response cycle.
  - Byte: lane addr[1:0], bit 7 replicated if sext, else zero-filled.
  - Half: lanes at addr[1], bit 15 replicated if sext, else zero-filled.
  - Word: unmodified.
- Read-after-write: a load accepted in the RESP cycle of a store to the same word returns the new data.
- Word index is (addr-BASE_ADDR)[log2(DEPTH_WORDS)+1:2]. No wrap-around; out-of-range addresses fault.
- req_valid while req_ready=0: ignored. The requester holds the request; the block does not latch it.
- Reset mid-operation: the pending response is dropped, with no rvalid after reset release. A store already committed at acceptance remains in the array.
- Outputs outside the response cycle: rdata and fault are held at 0 when rvalid=0.

Decomposition:
- Package mem_pkg:
  - MEMW_BYTE, MEMW_HALF, MEMW_WORD, MEMW_RSVD width constants, replacing the current defines in the hart.
  - dmem_state_t enum {IDLE, WAIT, RESP}.
  - Function misaligned(addr, width).
- Sub-module mem_align, purely combinational:
  - Store side: byte enables and lane-steered write data from addr[1:0], width, wdata.
  - Load side: extracted and extended result from the raw word, addr[1:0], width, sext.
  - The hart and any future cache reuse it.

Test Plan:
1. Word store then load, LATENCY=1: store addr=0x10, wdata=0xDEADBEEF, width=10 -> rvalid next cycle, fault=0. Load 0x10 -> rdata=0xDEADBEEF exactly one cycle after accept.
2. Byte/half steering and extension: store byte 0x80 to 0x13. Load byte 0x13 with sext=1 -> 0xFFFFFF80; with sext=0 -> 0x00000080. Load word 0x10 -> 0x80ADBEEF. Load half 0x12 with sext=1 -> 0xFFFF80AD.
3. Faults: half load at 0x11, word store at 0x22, width=11 at 0x0, address DEPTH_WORDS*4 -> each gives fault=1, rdata=0. Word 0x20 unchanged by the faulted store.
4. LATENCY=3 timing: accept at edge N -> req_ready=0 for 2 cycles, rvalid exactly one cycle, req_valid held during WAIT not re-accepted. Back-to-back request accepted in RESP -> next rvalid 3 cycles later.
5. Reset mid-operation: LATENCY=4, word store 0x12345678 to 0x40, reset asserted in WAIT -> rvalid never pulses. After reset release, load 0x40 -> 0x12345678.
6. Read-after-write back-to-back: store half 0xBEEF to 0x8 accepted, load 0x8 accepted in its RESP cycle -> rdata with sext=0 is 0x0000BEEF.
